// File: rtl/sigmoid_pkg.sv
// sigmoid_pkg
// Shared Q8.8 types and constants for the time-shared sigmoid datapath.
//   q88_t      : 16-bit Q8.8 word (8 integer bits, 8 fraction bits)
//   HALF / ONE : 0.5 and 1.0 in Q8.8
//   shr_zero   : logical right shift that yields zero for shift counts >= 16
package sigmoid_pkg;

    typedef logic [15:0] q88_t;

    localparam q88_t HALF = 16'h0080;
    localparam q88_t ONE  = 16'h0100;

    // The shift count comes from the 8-bit integer part of the operand, so it
    // can reach 255; anything from 16 upward must flush the value to zero.
    function automatic q88_t shr_zero(input q88_t v, input logic [7:0] n);
        return (n >= 8'd16) ? 16'h0000 : (v >> n[3:0]);
    endfunction

endpackage

// File: rtl/sigmoid_core.sv
// sigmoid_core
// Combinational piecewise sigmoid approximation on a Q8.8 operand.
// Ports:
//   x : Q8.8 two's-complement operand
//   y : Q8.8 result in the range 0x0000..0x0100
module sigmoid_core
    import sigmoid_pkg::*;
(
    input  q88_t x,
    output q88_t y
);

    q88_t       x1;
    logic [7:0] n;
    logic [7:0] f;

    always_comb begin
        x1 = x - ONE;
        n  = 8'h00;
        f  = 8'h00;
        y  = 16'h0000;
        if (!x[15]) begin
            n = x[15:8];
            f = x[7:0];
            y = ONE - shr_zero(HALF + {10'b0, f[7:2]}, n);
        end else begin
            // Negative side: bias by -1.0 so the inverted integer part gives
            // the distance from zero as a shift count.
            n = ~x1[15:8];
            f = x1[7:0];
            y = shr_zero(HALF - {10'b0, f[7:2]}, n);
        end
    end

endmodule

// File: rtl/sigmoid_rr_scheduler.sv
// sigmoid_rr_scheduler
// Round-robin front end sharing one sigmoid_core among NUM_REQ requesters.
// An operand register (S1) and a result register (S2) form a two-stage
// valid/ready pipeline; S2 drives the tagged response stream directly.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_data    : per-requester operand offers (Q8.8, 16 bits each)
//   req_ready             : one-hot grant, combinational
//   rsp_valid/rsp_ready   : response handshake
//   rsp_data/rsp_id       : Q8.8 result and originating requester index
//   busy                  : any pipeline stage occupied
//   done_cnt              : delivered responses, saturating at 0xFFFF
module sigmoid_rr_scheduler
    import sigmoid_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [16*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [15:0]           rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy,
    output logic [15:0]           done_cnt
);

    q88_t            req_x [NUM_REQ];
    logic [ID_W-1:0] ptr;

    logic            s1_valid;
    q88_t            s1_x;
    logic [ID_W-1:0] s1_id;
    logic            s2_valid;
    q88_t            s2_y;
    logic [ID_W-1:0] s2_id;

    logic            s1_adv;
    logic            s2_adv;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0] grant_id;
    q88_t            grant_x;
    logic            take;
    q88_t            core_y;
    int              idx;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_x[i] = req_data[16*i +: 16];
    end

    assign s2_adv = !s2_valid || rsp_ready;
    assign s1_adv = !s1_valid || s2_adv;

    // Rotating priority search starting at ptr; first valid requester wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        grant_x  = '0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!(|grant) && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
                grant_x    = req_x[idx];
            end
        end
    end

    // No grant while S1 is stuck, and none while reset is held.
    assign req_ready = (s1_adv && rst_n) ? grant : '0;
    assign take      = |req_ready;

    sigmoid_core u_core (
        .x (s1_x),
        .y (core_y)
    );

    // Stage S1: operand register and arbitration pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_id    <= '0;
            ptr      <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= take;
                if (take) begin
                    s1_x  <= grant_x;
                    s1_id <= grant_id;
                end
            end
            if (take) begin
                ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    // Stage S2: result register driving the response stream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_y     <= '0;
            s2_id    <= '0;
            done_cnt <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_y  <= core_y;
                    s2_id <= s1_id;
                end
            end
            if (s2_valid && rsp_ready && (done_cnt != 16'hFFFF)) begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_data  = s2_y;
    assign rsp_id    = s2_id;
    assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_sigmoid_rr_scheduler.sv
// tb_sigmoid_rr_scheduler
// Directed bench for sigmoid_rr_scheduler with hand-computed expectations.
module tb_sigmoid_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [15:0]           rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic                  busy;
    logic [15:0]           done_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_done = 0;

    // Expected results for the fairness stream operands
    logic [15:0] fair_x   [4] = '{16'h0000, 16'h0100, 16'h0280, 16'hFF00};
    logic [15:0] fair_y   [4] = '{16'h0080, 16'h00C0, 16'h00D8, 16'h0040};

    sigmoid_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_one(input int r, input logic [15:0] x, input logic [15:0] y);
        req_valid = 4'(1 << r);
        req_data[16*r +: 16] = x;
        #1;
        chk("one_grant", 32'(req_ready), 32'(1 << r));
        step();
        req_valid = '0;
        #1;
        chk("one_s1_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("one_s1_busy", 32'(busy), 32'd1);
        step();
        #1;
        chk("one_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("one_rsp_data", 32'(rsp_data), 32'(y));
        chk("one_rsp_id", 32'(rsp_id), 32'(r));
        step();
        #1;
        exp_done++;
        chk("one_drained", 32'(rsp_valid), 32'd0);
        chk("one_done_cnt", 32'(done_cnt), 32'(exp_done));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_data  = '0;
        rsp_ready = 1'b0;
        #13;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_done_cnt", 32'(done_cnt), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        req_valid = '0;
        rsp_ready = 1'b1;
        #4;
        rst_n = 1'b1;
        step();

        // Single operation and core value checks
        run_one(2, 16'h0000, 16'h0080);
        run_one(1, 16'h0100, 16'h00C0);
        run_one(0, 16'h0280, 16'h00D8);
        run_one(2, 16'h1000, 16'h0100);
        run_one(1, 16'hFF00, 16'h0040);
        run_one(2, 16'h8000, 16'h0000);
        run_one(3, 16'h7FFF, 16'h0100);

        // Fairness: ptr is back at 0 after the grant to requester 3
        for (int i = 0; i < 4; i++) req_data[16*i +: 16] = fair_x[i];
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= 2) begin
                chk("fair_rsp_id", 32'(rsp_id), 32'((k - 2) % 4));
                chk("fair_rsp_data", 32'(rsp_data), 32'(fair_y[(k - 2) % 4]));
            end else begin
                chk("fair_fill", 32'(rsp_valid), 32'd0);
            end
            step();
        end
        req_valid = '0;
        #1;
        chk("fair_tail_id6", 32'(rsp_id), 32'd2);
        step();
        #1;
        chk("fair_tail_id7", 32'(rsp_id), 32'd3);
        step();
        #1;
        chk("fair_empty", 32'(busy), 32'd0);
        exp_done += 8;
        chk("fair_done_cnt", 32'(done_cnt), 32'(exp_done));

        // Backpressure: rsp_ready low for 5 cycles mid-stream
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant0", 32'(req_ready), 32'b0001);
        step();
        #1;
        chk("bp_grant1", 32'(req_ready), 32'b0010);
        step();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_no_grant", 32'(req_ready), 32'd0);
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_data", 32'(rsp_data), 32'h0080);
            chk("bp_hold_id", 32'(rsp_id), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_rel_id0", 32'(rsp_id), 32'd0);
        chk("bp_rel_grant2", 32'(req_ready), 32'b0100);
        step();
        #1;
        chk("bp_rel_id1", 32'(rsp_id), 32'd1);
        chk("bp_rel_data1", 32'(rsp_data), 32'h00C0);
        chk("bp_rel_grant3", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        #1;
        chk("bp_rel_id2", 32'(rsp_id), 32'd2);
        chk("bp_rel_data2", 32'(rsp_data), 32'h00D8);
        step();
        #1;
        chk("bp_rel_id3", 32'(rsp_id), 32'd3);
        chk("bp_rel_data3", 32'(rsp_data), 32'h0040);
        step();
        #1;
        chk("bp_drained", 32'(rsp_valid), 32'd0);
        exp_done += 4;
        chk("bp_done_cnt", 32'(done_cnt), 32'(exp_done));

        // Reset with both stages full
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        step();
        step();
        #1;
        chk("mid_full_busy", 32'(busy), 32'd1);
        chk("mid_full_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_done_cnt", 32'(done_cnt), 32'd0);
        rsp_ready = 1'b1;
        #3;
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant0", 32'(req_ready), 32'b0001);
        step();
        #1;
        chk("post_rst_no_stale", 32'(rsp_valid), 32'd0);
        step();
        #1;
        chk("post_rst_first_id", 32'(rsp_id), 32'd0);
        chk("post_rst_first_valid", 32'(rsp_valid), 32'd1);

        // Counter saturation: stream continuously until past 0xFFFF
        for (int k = 0; k < 65545; k++) step();
        #1;
        chk("sat_done_cnt", 32'(done_cnt), 32'h0000FFFF);
        chk("sat_stream_valid", 32'(rsp_valid), 32'd1);
        step();
        step();
        #1;
        chk("sat_hold", 32'(done_cnt), 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sigmoid_rr_scheduler.md
# sigmoid_rr_scheduler

Time-shares one combinational Q8.8 sigmoid approximation core between `NUM_REQ` independent requesters. Round-robin arbitration accepts at most one operand per cycle; a two-stage valid/ready pipeline (operand register, result register) returns each tagged result on a single response stream. The block sits between the requesting engines and the shared sigmoid datapath and is the only path into it.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `ID_W`, `$clog2(NUM_REQ)`, response tag width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req_valid` in NUM_REQ: operand offered by requester i
- `req_data` in 16*NUM_REQ: Q8.8 two's-complement operand, slice i = bits [16i+15:16i]
- `req_ready` out NUM_REQ: one-hot grant; transfer when `req_valid[i] & req_ready[i]`
- `rsp_valid` out 1: result available
- `rsp_ready` in 1: consumer accepts result
- `rsp_data` out 16: Q8.8 result, range 0x0000..0x0100
- `rsp_id` out ID_W: index of originating requester
- `busy` out 1: any pipeline stage valid
- `done_cnt` out 16: responses delivered, saturating at 0xFFFF

## Operation
- Core function (x = Q8.8): x ≥ 0: n = x[15:8], f = x[7:0]; y = 0x0100 − ((0x0080 + (f>>2)) >> n). x < 0: x1 = x − 0x0100; n = ~x1[15:8], f = x1[7:0]; y = (0x0080 − (f>>2)) >> n. All arithmetic 16-bit unsigned, wrap on overflow; shift ≥ 16 yields 0.
- Stage 1 (S1): `s1_valid`, `s1_x`, `s1_id`. Stage 2 (S2): `s2_valid`, `s2_y`, `s2_id`; S2 drives `rsp_*` directly.
- Pipeline advance: `s2_adv = !s2_valid | rsp_ready`; `s1_adv = !s1_valid | s2_adv`.
- Arbitration runs only when `s1_adv`; otherwise `req_ready` = 0.
- Round-robin: search starts at `ptr`, wraps modulo NUM_REQ; first valid requester granted. On grant to i, `ptr` ← (i+1) mod NUM_REQ. No grant → `ptr` unchanged.
- `req_ready` is combinational from `req_valid`, `ptr`, stage state; requesters must hold `req_data` stable while `req_valid` is high and not granted.
- Core is evaluated on `s1_x`; result captured into S2 when `s2_adv`.
- `done_cnt` increments on `rsp_valid & rsp_ready`, holds at 0xFFFF.
- `busy` = `s1_valid | s2_valid`.

## Timing
- Reset (async assert, sync-released by `clk` domain externally): `s1_valid`=`s2_valid`=0, `ptr`=0, `done_cnt`=0, `rsp_data`=0, `rsp_id`=0, `rsp_valid`=0, `busy`=0, `req_ready`=0 while `rst_n` low.
- Latency: grant in cycle N → `rsp_valid` high in cycle N+2 (S1 at N+1, S2 at N+2).
- Throughput: one result per cycle with `rsp_ready` held high.
- Backpressure: `rsp_ready` low with S2 full → S2 holds `rsp_data`/`rsp_id` stable; S1 holds if full; no grants while S1 held full. Both stages fill, then stall; no loss, no duplication.
- Simultaneous accept and grant in one cycle: S2 reloads from S1, S1 reloads from grant; `rsp_valid` stays high.
- Reset mid-operation: all in-flight operands discarded, no partial response.
- Order: responses leave in grant order.

## Structure
- Package `sigmoid_pkg`: Q8.8 constants `HALF`=16'h0080, `ONE`=16'h0100, typedef `q88_t` (logic [15:0]).
- Sub-module `sigmoid_core` (combinational, x in, y out) implementing the core function; scheduler instantiates exactly one.
- Round-robin arbiter kept inline.

## Test plan
- Single op: reset, requester 2 sends 0x0000 → 2 cycles later `rsp_valid`, `rsp_data`=0x0080, `rsp_id`=2, `done_cnt`=1.
- Value checks: 0x0100 → 0x00C0; 0x0280 → 0x00D8; 0x1000 → 0x0100; 0xFF00 → 0x0040.
- Fairness: all 4 requesters valid continuously, `rsp_ready`=1 → grants 0,1,2,3,0,… one per cycle; `rsp_id` sequence identical, 2 cycles delayed.
- Backpressure: `rsp_ready`=0 for 5 cycles during stream → exactly 2 grants then `req_ready`=0, `rsp_data` stable; release → ordered, lossless drain.
- Reset mid-stream: assert `rst_n`=0 with both stages full → `rsp_valid`, `busy` drop immediately; after release first grant goes to requester 0.
- Counter saturation: force 65 536+ accepted responses → `done_cnt` holds 0xFFFF.
